// File: rtl/mpsoc2d_wb_ext_pkg.sv
// ============================================================================
// Module  : mpsoc2d_wb_ext_pkg
// Brief   : Wishbone cycle/burst type encodings, responder states and the
//           burst next-word helper.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpsoc2d_wb_ext_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } wb_cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } wb_bte_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } resp_state_e;

  // Wrapping bursts only roll the low index bits; the rest stays pinned.
  function automatic logic [29:0] wb_next_word(input logic [29:0] idx, input wb_bte_e bte);
    logic [29:0] nxt;
    nxt = idx;
    case (bte)
      WRAP4:   nxt[1:0] = idx[1:0] + 2'd1;
      WRAP8:   nxt[2:0] = idx[2:0] + 3'd1;
      WRAP16:  nxt[3:0] = idx[3:0] + 4'd1;
      default: nxt      = idx + 30'd1;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpsoc2d_wb_ext_burst_addr.sv
// ============================================================================
// Module  : mpsoc2d_wb_ext_burst_addr
// Brief   : Holds the word address of the beat being served and presents the
//           following word address for read-data prefetch.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpsoc2d_wb_ext_burst_addr
  import mpsoc2d_wb_ext_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [29:0] i_load_word,
  input  logic [1:0]  i_load_bte,
  output logic [29:0] o_cur_word,
  output logic [29:0] o_next_word
);

  logic [29:0] r_cur;
  wb_bte_e     r_bte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur <= '0;
      r_bte <= LINEAR;
    end else if (i_load) begin
      r_cur <= i_load_word;
      r_bte <= wb_bte_e'(i_load_bte);
    end else if (i_advance) begin
      r_cur <= o_next_word;
    end
  end

  assign o_cur_word  = r_cur;
  assign o_next_word = wb_next_word(r_cur, r_bte);

endmodule

`default_nettype wire

// File: rtl/mpsoc2d_wb_ext_responder.sv
// ============================================================================
// Module  : mpsoc2d_wb_ext_responder
// Brief   : Wishbone B3 SRAM-window slave for the or1k_mpsoc2d external port;
//           classic + CTI/BTE bursts, err outside the window. Optional retry
//           injection when MPSOC2D_WB_EXT_RTY_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpsoc2d_wb_ext_responder
  import mpsoc2d_wb_ext_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RTY_PERIOD  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_cab_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int unsigned c_idx_w     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] c_base_word = BASE_ADDR[31:2];
  localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);
  localparam logic [3:0]  c_wait      = 4'(WAIT_STATES);

  logic [31:0]        r_mem [MEM_WORDS];
  resp_state_e        r_state, w_next;
  logic [3:0]         r_wait_cnt;
  logic               r_err, r_burst;
  logic [31:0]        r_dat;
  logic               w_beat, w_accept, w_req_in_win, w_cur_in_win;
  logic               w_rty_hit, w_rty_pend, w_advance, w_wr;
  logic               w_ack, w_err, w_rty;
  logic [29:0]        w_cur_word, w_next_word;
  logic [c_idx_w-1:0] w_rd_idx;
  logic               w_unused;

  assign w_beat       = wb_cyc_i & wb_stb_i;
  assign w_accept     = (r_state == IDLE) & w_beat;
  assign w_req_in_win = (wb_adr_i[31:2] - c_base_word) < c_mem_words;
  assign w_cur_in_win = (w_cur_word - c_base_word) < c_mem_words;

`ifdef MPSOC2D_WB_EXT_RTY_EN
  localparam int unsigned c_rty_w = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;
  logic [c_rty_w-1:0] r_rty_cnt;
  logic               r_rty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rty_cnt <= '0;
      r_rty     <= 1'b0;
    end else if (w_accept) begin
      r_rty_cnt <= (r_rty_cnt == c_rty_w'(RTY_PERIOD - 1)) ? '0 : r_rty_cnt + 1'b1;
      r_rty     <= w_rty_hit;
    end
  end

  assign w_rty_hit  = (r_rty_cnt == '0);
  assign w_rty_pend = r_rty;
`else
  assign w_rty_hit  = 1'b0;
  assign w_rty_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_beat) w_next = (c_wait == 4'd0) ? RESP : WAIT;
      WAIT:    if (!wb_cyc_i) w_next = IDLE;
               else if (r_wait_cnt == 4'd1) w_next = RESP;
      RESP:    w_next = (r_burst && w_ack) ? BURST : IDLE;
      BURST:   if (!w_beat || w_err || (w_ack && wb_cti_i == EOB)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Terminations are qualified by the live strobe so an abort never sees one.
  always_comb begin
    w_ack = 1'b0;
    w_err = 1'b0;
    w_rty = 1'b0;
    case (r_state)
      RESP: begin
        w_rty = w_beat & w_rty_pend;
        w_err = w_beat & ~w_rty_pend & r_err;
        w_ack = w_beat & ~w_rty_pend & ~r_err;
      end
      BURST: begin
        w_err = w_beat & ~w_cur_in_win;
        w_ack = w_beat & w_cur_in_win;
      end
      default: ;
    endcase
  end

  assign wb_ack_o = w_ack;
  assign wb_err_o = w_err;
  assign wb_rty_o = w_rty;
  assign wb_dat_o = r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_burst    <= 1'b0;
    end else if (w_accept) begin
      r_wait_cnt <= c_wait;
      r_err      <= ~w_req_in_win;
      r_burst    <= (c_wait == 4'd0) & (wb_cti_i == INCR) & w_req_in_win & ~w_rty_hit;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  assign w_advance = w_ack & (((r_state == RESP) & r_burst) |
                              ((r_state == BURST) & (wb_cti_i != EOB)));

  mpsoc2d_wb_ext_burst_addr u_burst_addr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_advance   (w_advance),
    .i_load_word (wb_adr_i[31:2]),
    .i_load_bte  (wb_bte_i),
    .o_cur_word  (w_cur_word),
    .o_next_word (w_next_word)
  );

  // Fetch the request word on accept, then the following beat's word so burst
  // data is ready in the very next ack cycle.
  assign w_rd_idx = w_accept ? wb_adr_i[2 +: c_idx_w] : w_next_word[c_idx_w-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_dat <= '0;
    else if (w_accept || w_advance) r_dat <= r_mem[w_rd_idx];
  end

  assign w_wr = w_ack & wb_we_i;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) r_mem[w_cur_word[c_idx_w-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign w_unused = &{1'b0, wb_cab_i, wb_adr_i[1:0], w_next_word[29:c_idx_w], RTY_PERIOD[0]};

endmodule

`default_nettype wire

// File: tb/tb_mpsoc2d_wb_ext_responder.sv
// ============================================================================
// Module  : tb_mpsoc2d_wb_ext_responder
// Brief   : Self-checking bench: two responders (0 and 3 wait states) against
//           a word-array reference model. Honours MPSOC2D_WB_EXT_RTY_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mpsoc2d_wb_ext_responder;

  localparam logic [31:0] c_base       = 32'h8000_0000;
  localparam int          c_words      = 64;
  localparam int          c_rty_period = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr [2];
  logic [31:0] dat_w [2];
  logic [31:0] dat_r [2];
  logic [3:0]  sel [2];
  logic [2:0]  cti [2];
  logic [1:0]  bte [2];
  logic        we [2], cyc [2], stb [2], cab [2];
  logic        ack [2], err [2], rty [2];

  mpsoc2d_wb_ext_responder #(
    .BASE_ADDR(c_base), .MEM_WORDS(c_words), .WAIT_STATES(0), .RTY_PERIOD(c_rty_period)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]), .wb_sel_i(sel[0]),
    .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_cab_i(cab[0]),
    .wb_cti_i(cti[0]), .wb_bte_i(bte[0]), .wb_dat_o(dat_r[0]), .wb_ack_o(ack[0]),
    .wb_err_o(err[0]), .wb_rty_o(rty[0])
  );

  mpsoc2d_wb_ext_responder #(
    .BASE_ADDR(c_base), .MEM_WORDS(c_words), .WAIT_STATES(3), .RTY_PERIOD(c_rty_period)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]), .wb_sel_i(sel[1]),
    .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_cab_i(cab[1]),
    .wb_cti_i(cti[1]), .wb_bte_i(bte[1]), .wb_dat_o(dat_r[1]), .wb_ack_o(ack[1]),
    .wb_err_o(err[1]), .wb_rty_o(rty[1])
  );

  logic [31:0] mdl_mem [2][c_words];
  int          acc_cnt [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - c_base;
    return off < 32'(c_words * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % c_words);
  endfunction

  function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] b);
    logic [31:0] w;
    logic [31:0] n;
    w = a >> 2;
    if (b == 2'b00) begin
      w = w + 1;
    end else begin
      n = 32'd4 << (int'(b) - 1);
      w = (w / n) * n + (w + 1) % n;
    end
    return w << 2;
  endfunction

  function automatic bit rty_due(input int d);
`ifdef MPSOC2D_WB_EXT_RTY_EN
    return (acc_cnt[d] % c_rty_period) == 0;
`else
    return (d < 0);
`endif
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    int i;
    i = widx(a);
    for (int b = 0; b < 4; b++) if (s[b]) mdl_mem[d][i][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic classic(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output bit was_rty);
    int          lat;
    logic [2:0]  got, exp;
    was_rty = rty_due(d);
    exp = was_rty ? 3'b100 : (in_win(a) ? 3'b001 : 3'b010);
    @(negedge clk);
    adr[d] = a; dat_w[d] = wd; sel[d] = s; we[d] = wr;
    cti[d] = 3'b000; bte[d] = 2'b00; cyc[d] = 1'b1; stb[d] = 1'b1;
    acc_cnt[d]++;
    lat = 0;
    got = 3'b000;
    while (got == 3'b000 && lat < 20) begin
      @(negedge clk);
      lat++;
      got = {rty[d], err[d], ack[d]};
    end
    check_val($sformatf("classic%0d_resp_%08h", d, a), 32'(got), 32'(exp));
    check_val($sformatf("classic%0d_latency", d), lat, (d == 0) ? 1 : 4);
    if (!wr && got == 3'b001) check_val($sformatf("classic%0d_rdata_%08h", d, a), dat_r[d], mdl_mem[d][widx(a)]);
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    if (wr && exp == 3'b001) mdl_write(d, a, wd, s);
  endtask

  task automatic burst(input int d, input bit wr, input logic [31:0] a0, input logic [1:0] b, input int nb);
    logic [31:0] a;
    logic [2:0]  got, exp;
    bit          first_rty, done;
    a = a0;
    first_rty = rty_due(d);
    @(negedge clk);
    adr[d] = a; we[d] = wr; sel[d] = 4'($urandom); dat_w[d] = $urandom;
    cti[d] = 3'b010; bte[d] = b; cyc[d] = 1'b1; stb[d] = 1'b1;
    acc_cnt[d]++;
    done = 1'b0;
    for (int k = 0; k < nb && !done; k++) begin
      @(negedge clk);
      got = {rty[d], err[d], ack[d]};
      if (k == 0 && first_rty) exp = 3'b100;
      else                     exp = in_win(a) ? 3'b001 : 3'b010;
      check_val($sformatf("burst%0d_beat%0d_%08h", d, k, a), 32'(got), 32'(exp));
      if (!wr && got == 3'b001) check_val($sformatf("burst%0d_rdata%0d", d, k), dat_r[d], mdl_mem[d][widx(a)]);
      if (wr && exp == 3'b001) mdl_write(d, a, dat_w[d], sel[d]);
      done = (exp != 3'b001) || (k == nb - 1);
      @(posedge clk); #1;
      if (!done) begin
        a = next_adr(a, b);
        adr[d] = a; dat_w[d] = $urandom; sel[d] = 4'($urandom);
        cti[d] = (k + 1 == nb - 1) ? 3'b111 : 3'b010;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; cti[d] = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          r;
    int          seen;
    int          op;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; dat_w[d] = '0; sel[d] = '0; cti[d] = '0; bte[d] = '0;
      we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; cab[d] = 1'b0; acc_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("reset%0d_resp", d), 32'({rty[d], err[d], ack[d]}), 32'd0);
      check_val($sformatf("reset%0d_dat", d), dat_r[d], 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Give every SRAM word a known value.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < c_words; w++)
        do classic(d, 1'b1, c_base + 32'(w * 4), $urandom, 4'hF, r); while (r);

    classic(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
    classic(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, r);

    classic(1, 1'b1, 32'h8000_0014, 32'h0, 4'hF, r);
    classic(1, 1'b1, 32'h8000_0014, 32'h0000_AB00, 4'b0010, r);
    classic(1, 1'b0, 32'h8000_0014, 32'h0, 4'hF, r);

    burst(0, 1'b0, c_base + 32'd24, 2'b01, 4);
    burst(0, 1'b0, c_base + 32'd252, 2'b00, 4);

    classic(0, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, r);
    classic(0, 1'b0, c_base + 32'd252, 32'h0, 4'hF, r);

    // Abort during wait states: no response, no write.
    @(negedge clk);
    adr[1] = c_base + 32'd40; dat_w[1] = 32'hFFFF_FFFF; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    acc_cnt[1]++;
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] || err[1] || rty[1]) seen++;
    end
    check_val("abort_no_resp", seen, 0);
    classic(1, 1'b0, c_base + 32'd40, 32'h0, 4'hF, r);

    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = $urandom & 32'hFFFF_FFFC;
      else                           a = c_base + 32'($urandom_range(0, c_words - 1) * 4);
      if (op < 5) classic(0, op[0], a, $urandom, 4'($urandom), r);
      else if (op < 8) burst(0, op[0], a, 2'($urandom), $urandom_range(2, 6));
      else classic(1, op[0], a, $urandom, 4'($urandom), r);
    end

    // Reset in the middle of a burst clears the terminations immediately.
    if (rty_due(0)) classic(0, 1'b0, c_base, 32'h0, 4'hF, r);
    @(negedge clk);
    adr[0] = c_base + 32'd32; we[0] = 1'b0; cti[0] = 3'b010; bte[0] = 2'b00;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    acc_cnt[0]++;
    @(negedge clk);
    check_val("midrst_beat0", 32'({rty[0], err[0], ack[0]}), 32'd1);
    check_val("midrst_data0", dat_r[0], mdl_mem[0][8]);
    @(posedge clk); #1 adr[0] = c_base + 32'd36;
    @(negedge clk);
    check_val("midrst_beat1", 32'({rty[0], err[0], ack[0]}), 32'd1);
    check_val("midrst_data1", dat_r[0], mdl_mem[0][9]);
    @(posedge clk); #1 adr[0] = c_base + 32'd40;
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_resp", 32'({rty[0], err[0], ack[0]}), 32'd0);
    check_val("midrst_dat", dat_r[0], 32'd0);
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0; cti[0] = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;

    // Nine reads from a fresh retry counter.
    for (int k = 0; k < 9; k++) classic(0, 1'b0, c_base + 32'(k * 4), 32'h0, 4'hF, r);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
